// File: rtl/session_timeout_supervisor.sv
// Inactivity supervisor for an ATM customer session.
// Arms on card insertion and counts idle cycles, restarting the count on any
// user activity. A warning window precedes the limit. At the limit the block
// parks in EXPIRED until the host acknowledges. Every output comes straight
// from a flop, so no input has a combinational path to an output.
module session_timeout_supervisor #(
  parameter int CNT_W     = 32,
  parameter int EXP_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 card_in,
  input  logic                 activity,
  input  logic                 session_end,
  input  logic                 ack,
  input  logic [CNT_W-1:0]     timeout_cycles,
  input  logic [CNT_W-1:0]     warn_cycles,
  output logic                 session_active,
  output logic                 warn,
  output logic                 expired,
  output logic                 expire_pulse,
  output logic [EXP_CNT_W-1:0] expiry_count,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_WARN    = 2'd2,
    S_EXPIRED = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);
  localparam logic [EXP_CNT_W-1:0] EXP_ONE = EXP_CNT_W'(1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     t_q, t_d;
  logic [CNT_W-1:0]     w_q, w_d;
  logic [EXP_CNT_W-1:0] exp_cnt_q, exp_cnt_d;
  logic                 pulse_q, pulse_d;
  logic                 session_active_q, session_active_d;
  logic                 warn_q, warn_d;
  logic                 expired_q, expired_d;

  // Conditions evaluated on the latched limits and the sampled counter
  logic at_limit;
  logic at_warn_point;
  logic restart_in_warn;

  // A restart lands directly in WARN when the window covers the whole limit
  always_comb begin
    at_limit        = (t_q != '0) && (cnt_q == t_q - CNT_ONE);
    at_warn_point   = (t_q != '0) && (w_q != '0) && (w_q < t_q) &&
                      (cnt_q == t_q - w_q - CNT_ONE);
    restart_in_warn = (t_q != '0) && (w_q >= t_q);
  end

  // Next state, counter and latched limits; the output flops follow state_d
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    t_d       = t_q;
    w_d       = w_q;
    exp_cnt_d = exp_cnt_q;
    pulse_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (card_in) begin
          t_d     = timeout_cycles;
          w_d     = warn_cycles;
          cnt_d   = '0;
          state_d = ((timeout_cycles != '0) && (warn_cycles >= timeout_cycles))
                    ? S_WARN : S_ACTIVE;
        end
      end
      S_ACTIVE, S_WARN: begin
        if (session_end) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (activity) begin
          cnt_d   = '0;
          state_d = restart_in_warn ? S_WARN : S_ACTIVE;
        end else if (at_limit) begin
          // Counter is held; it is cleared again on the way out of EXPIRED
          state_d = S_EXPIRED;
          pulse_d = 1'b1;
          if (exp_cnt_q != '1) exp_cnt_d = exp_cnt_q + EXP_ONE;
        end else begin
          // Saturate instead of wrapping so a disabled timeout never aliases
          if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
          if ((state_q == S_ACTIVE) && at_warn_point) state_d = S_WARN;
        end
      end
      S_EXPIRED: begin
        if (ack) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    session_active_d = (state_d == S_ACTIVE) || (state_d == S_WARN);
    warn_d           = (state_d == S_WARN);
    expired_d        = (state_d == S_EXPIRED);
  end

  // State, counters and registered outputs; asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      t_q              <= '0;
      w_q              <= '0;
      exp_cnt_q        <= '0;
      pulse_q          <= 1'b0;
      session_active_q <= 1'b0;
      warn_q           <= 1'b0;
      expired_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      t_q              <= t_d;
      w_q              <= w_d;
      exp_cnt_q        <= exp_cnt_d;
      pulse_q          <= pulse_d;
      session_active_q <= session_active_d;
      warn_q           <= warn_d;
      expired_q        <= expired_d;
    end
  end

  assign state          = state_q;
  assign session_active = session_active_q;
  assign warn           = warn_q;
  assign expired        = expired_q;
  assign expire_pulse   = pulse_q;
  assign expiry_count   = exp_cnt_q;

endmodule

// File: tb/tb_session_timeout_supervisor.sv
// Scoreboard bench for session_timeout_supervisor. The driver pushes the
// hand-derived expected outputs for each clock edge it causes; a separate
// monitor pops one record per edge (or per asynchronous-reset probe) and
// compares it against the DUT outputs.
module tb_session_timeout_supervisor;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_ACT = 2'd1, ST_WARN = 2'd2, ST_EXP = 2'd3;

  typedef struct packed {
    logic [1:0] st;
    logic       sa;
    logic       wr;
    logic       ex;
    logic       ep;
    logic [7:0] ec;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        card_in = 1'b0, activity = 1'b0, session_end = 1'b0, ack = 1'b0;
  logic [31:0] timeout_cycles = '0, warn_cycles = '0;
  logic        session_active, warn, expired, expire_pulse;
  logic [7:0]  expiry_count;
  logic [1:0]  state;

  rec_t q[$];
  int   tid_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   tid   = 0;
  logic [7:0] ecnt = '0;
  event async_chk;

  session_timeout_supervisor #(.CNT_W(32), .EXP_CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .card_in(card_in), .activity(activity), .session_end(session_end), .ack(ack),
    .timeout_cycles(timeout_cycles), .warn_cycles(warn_cycles),
    .session_active(session_active), .warn(warn), .expired(expired),
    .expire_pulse(expire_pulse), .expiry_count(expiry_count), .state(state)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish (time %0t)", $time);
    $fatal(1, "watchdog");
  end

  function automatic rec_t mk(input logic [1:0] es, input logic ep);
    rec_t r;
    r.st = es;
    r.sa = (es == ST_ACT) || (es == ST_WARN);
    r.wr = (es == ST_WARN);
    r.ex = (es == ST_EXP);
    r.ep = ep;
    r.ec = ecnt;
    return r;
  endfunction

  // Drive one cycle of inputs and record what the following edge must produce
  task automatic step(input logic c, a, s, k, input logic [1:0] es, input logic ep);
    @(negedge clk);
    card_in = c; activity = a; session_end = s; ack = k;
    if (ep && ecnt != 8'hFF) ecnt = ecnt + 8'd1;
    q.push_back(mk(es, ep));
    tid_q.push_back(tid);
  endtask

  task automatic nop(input logic [1:0] es, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, es, 1'b0);
  endtask

  // Pull reset low between edges and expect every output cleared at once
  task automatic reset_probe();
    rst = 1'b0;
    ecnt = '0;
    q.push_back(mk(ST_IDLE, 1'b0));
    tid_q.push_back(tid);
    ->async_chk;
  endtask

  // Monitor: one record per clock edge, or per reset probe
  initial forever begin
    rec_t e, a;
    int   t;
    @(posedge clk or async_chk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      t = tid_q.pop_front();
      a = '{st: state, sa: session_active, wr: warn, ex: expired, ep: expire_pulse, ec: expiry_count};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL test%0d_cmp%0d got st=%0d sa=%b wr=%b ex=%b ep=%b ec=%0d want st=%0d sa=%b wr=%b ex=%b ep=%b ec=%0d",
                 t, n_cmp, a.st, a.sa, a.wr, a.ex, a.ep, a.ec, e.st, e.sa, e.wr, e.ex, e.ep, e.ec);
      end
    end
  end

  initial begin
    // Test 0: reset state
    #3;
    reset_probe();
    @(negedge clk);
    rst = 1'b1;

    // Test 1: T=10 W=3, no activity. WARN edges 7..9, EXPIRED at 10
    tid = 1; timeout_cycles = 10; warn_cycles = 3;
    step(1, 0, 0, 0, ST_ACT, 0);              // edge 0
    nop(ST_ACT, 6);                           // edges 1..6
    nop(ST_WARN, 3);                          // edges 7..9
    step(0, 0, 0, 0, ST_EXP, 1);              // edge 10, count -> 1
    nop(ST_EXP, 1);
    step(0, 0, 0, 1, ST_IDLE, 0);

    // Test 2: activity at edge 8 inside WARN; card_in mid-session ignored
    tid = 2;
    step(1, 0, 0, 0, ST_ACT, 0);              // edge 0
    nop(ST_ACT, 2);                           // edges 1..2
    step(1, 0, 0, 0, ST_ACT, 0);              // edge 3, card_in ignored
    nop(ST_ACT, 3);                           // edges 4..6
    step(0, 0, 0, 0, ST_WARN, 0);             // edge 7
    step(0, 1, 0, 0, ST_ACT, 0);              // edge 8
    nop(ST_ACT, 6);                           // edges 9..14
    nop(ST_WARN, 3);                          // edges 15..17
    step(0, 0, 0, 0, ST_EXP, 1);              // edge 18, count -> 2
    step(0, 0, 0, 1, ST_IDLE, 0);             // ack on entry cycle

    // Test 3: session_end with activity at edge 9, then ack+card_in in IDLE
    tid = 3;
    step(1, 0, 0, 0, ST_ACT, 0);
    nop(ST_ACT, 6);
    nop(ST_WARN, 2);                          // edges 7..8
    step(0, 1, 1, 0, ST_IDLE, 0);             // edge 9
    step(0, 1, 0, 1, ST_IDLE, 0);             // ignored in IDLE
    nop(ST_IDLE, 12);                         // no expiry appears
    step(1, 0, 0, 1, ST_ACT, 0);              // card_in wins over ack
    step(0, 0, 1, 0, ST_IDLE, 0);

    // Test 4: T=0 disables expiry and warning
    tid = 4; timeout_cycles = 0; warn_cycles = 5;
    step(1, 0, 0, 0, ST_ACT, 0);
    nop(ST_ACT, 100);
    step(0, 0, 1, 0, ST_IDLE, 0);

    // Test 5: T=5 W=8 enters WARN directly; mid-session limit change ignored
    tid = 5; timeout_cycles = 5; warn_cycles = 8;
    step(1, 0, 0, 0, ST_WARN, 0);             // edge 0
    nop(ST_WARN, 1);                          // edge 1
    timeout_cycles = 3; warn_cycles = 0;
    nop(ST_WARN, 3);                          // edges 2..4
    step(0, 0, 0, 0, ST_EXP, 1);              // edge 5, count -> 3
    step(1, 1, 1, 0, ST_EXP, 0);              // ignored in EXPIRED
    nop(ST_EXP, 3);
    step(0, 0, 0, 1, ST_IDLE, 0);
    // new session now picks up T=3 W=0: no WARN, expire at edge 3
    step(1, 0, 0, 0, ST_ACT, 0);
    nop(ST_ACT, 2);
    step(0, 0, 0, 0, ST_EXP, 1);              // count -> 4
    step(0, 0, 0, 1, ST_IDLE, 0);

    // Test 6: saturate expiry_count with T=1
    tid = 6; timeout_cycles = 1; warn_cycles = 0;
    for (int i = 0; i < 256; i++) begin
      step(1, 0, 0, 0, ST_ACT, 0);
      step(0, 0, 0, 0, ST_EXP, 1);
      step(0, 0, 0, 1, ST_IDLE, 0);
    end

    // Test 7: asynchronous reset while in WARN, then a clean restart
    tid = 7; timeout_cycles = 10; warn_cycles = 3;
    step(1, 0, 0, 0, ST_ACT, 0);
    nop(ST_ACT, 6);
    step(0, 0, 0, 0, ST_WARN, 0);
    @(posedge clk);
    #3;
    card_in = 1'b0;
    reset_probe();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step(1, 0, 0, 0, ST_ACT, 0);
    nop(ST_ACT, 6);
    step(0, 0, 0, 0, ST_WARN, 0);

    // Drain: every expected record must have been consumed
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d records left, want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/session_timeout_supervisor.md
Name: session_timeout_supervisor

Overview:
- Inactivity supervisor for an ATM customer session.
- Arms when a card is inserted and counts idle cycles. Restarts the count on every user activity pulse.
- Raises a warning window before the session limit. Forces an expiry state that the host must acknowledge.
- Sits between the keypad/card front end and the transaction FSM. The transaction FSM uses `expired` to abort and eject the card.

Parameters:
- CNT_W, 32: width of the idle counter and of the `timeout_cycles`/`warn_cycles` inputs.
- EXP_CNT_W, 8: width of the saturating expiry-event counter.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- card_in, input, 1: session start request; honoured only in IDLE.
- activity, input, 1: one-cycle user activity pulse (key press, menu select).
- session_end, input, 1: normal session termination from the transaction FSM.
- ack, input, 1: host acknowledge of an expiry; honoured only in EXPIRED.
- timeout_cycles, input, CNT_W: idle limit T in cycles; 0 disables expiry.
- warn_cycles, input, CNT_W: warning window W in cycles before expiry.
- session_active, output, 1: high in ACTIVE or WARN.
- warn, output, 1: high in WARN.
- expired, output, 1: high in EXPIRED.
- expire_pulse, output, 1: one-cycle pulse on the first cycle of EXPIRED.
- expiry_count, output, EXP_CNT_W: number of expiries since reset; saturates at all-ones.
- state, output, 2: state code: IDLE=0, ACTIVE=1, WARN=2, EXPIRED=3.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; idle counter=0; latched T and W=0.
  - All outputs 0, expiry_count=0.
  - A reset in any state, including mid-session, returns to IDLE immediately.
- All outputs are registered, derived from state and counters; no combinational input-to-output path.
- IDLE:
  - card_in=1 → latch T_l=timeout_cycles and W_l=warn_cycles, and clear the counter.
  - Next state is WARN if T_l≠0 and W_l≥T_l; otherwise ACTIVE.
  - Changes to `timeout_cycles`/`warn_cycles` during a session are ignored until the next IDLE exit.
  - activity, session_end and ack are ignored in IDLE.
- ACTIVE/WARN, resolved in this priority order each cycle:
  - 1) session_end=1 → IDLE, counter=0.
  - 2) activity=1 → counter=0. Next state is WARN if T_l≠0 and W_l≥T_l; otherwise ACTIVE.
  - 3) T_l≠0 and sampled counter==T_l−1 → EXPIRED. Counter is held; expiry_count increments unless saturated.
  - 4) Otherwise counter+1. ACTIVE→WARN when T_l≠0, W_l≠0, W_l<T_l and sampled counter==T_l−W_l−1.
- Timing consequences:
  - warn rises T−W cycles after the entry edge and lasts W cycles.
  - expired rises T cycles after the entry edge, or after the last activity edge.
- T_l=0: never WARN, never EXPIRED. The counter saturates at all-ones, with no wrap.
- W_l=0: WARN is never entered.
- card_in is ignored outside IDLE.
- EXPIRED:
  - expired=1; expire_pulse=1 only on the entry cycle.
  - Holds until ack=1, then → IDLE with counter=0.
  - activity, card_in and session_end are ignored.
  - ack=1 on the entry cycle is honoured: expired is high for exactly 1 cycle.
- Simultaneous events:
  - session_end beats activity; activity beats expiry in the same cycle.
  - card_in and ack together in IDLE: card_in wins, because ack is ignored in IDLE.

Test Plan:
- T=10, W=3, card_in pulse at edge 0, no activity → warn=1 from edge 7 to edge 9; expired=1 and expire_pulse=1 at edge 10; expiry_count=1; state=3.
- T=10, W=3, activity pulse at edge 8 (inside WARN) → warn drops at edge 8, state=1; warn rises at edge 15; expired at edge 18.
- T=10, W=3, session_end and activity together at edge 9 → state=0, counter=0, no expiry, expiry_count unchanged.
- T=0, card_in, run 100 cycles → session_active=1, warn=0, expired=0 throughout.
- T=5, W=8 (W≥T), card_in → state=2 immediately after the entry edge. Expire at edge 5, hold 4 cycles, ack → IDLE. Change timeout_cycles mid-session and confirm no effect on timing.
- Force 256 expiries with EXP_CNT_W=8 → expiry_count saturates at 255. Assert rst=0 while in WARN → all outputs 0 asynchronously, state=0.
